// File: rtl/clint_rd_arbiter.sv
// clint_rd_arbiter: round-robin two-master arbiter for the CLINT AXI4-Lite read channels.
// One read is outstanding at a time; the grant is held from AR acceptance until the R handshake.
module clint_rd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIRST_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              owner_q, owner_d, last_q, last_d;
    logic              win, in_idle, in_addr, in_data, own_rready, to_m0, to_m1;

    // Outputs are qualified by rst so they drop the instant reset asserts.
    assign in_idle    = rst && state_q == IDLE;
    assign in_addr    = rst && state_q == ADDR;
    assign in_data    = rst && state_q == DATA;
    assign win        = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
    assign own_rready = owner_q ? m1_rready : m0_rready;
    assign to_m0      = in_data && !owner_q;
    assign to_m1      = in_data && owner_q;

    assign m0_arready = in_idle && m0_arvalid && !win;
    assign m1_arready = in_idle && m1_arvalid && win;
    assign s_arvalid  = in_addr;
    assign s_araddr   = in_addr ? addr_q : '0;
    assign s_rready   = in_data && own_rready;

    assign m0_rvalid  = to_m0 && s_rvalid;
    assign m0_rdata   = to_m0 ? s_rdata : '0;
    assign m0_rresp   = to_m0 ? s_rresp : 2'b00;
    assign m1_rvalid  = to_m1 && s_rvalid;
    assign m1_rdata   = to_m1 ? s_rdata : '0;
    assign m1_rresp   = to_m1 ? s_rresp : 2'b00;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (m0_arvalid || m1_arvalid) begin
                addr_d  = win ? m1_araddr : m0_araddr;
                owner_d = win;
                state_d = ADDR;
            end
            ADDR: if (s_arready) state_d = DATA;
            DATA: if (s_rvalid && own_rready) begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= (FIRST_PRIO == 0);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_clint_rd_arbiter.sv
// tb_clint_rd_arbiter: directed checks of the CLINT read arbiter with a hand-driven slave.
module tb_clint_rd_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m0_araddr = '0, m1_araddr = '0, s_araddr, s_rdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp = '0;
    logic        m0_arvalid = 0, m0_arready, m0_rvalid, m0_rready = 0;
    logic        m1_arvalid = 0, m1_arready, m1_rvalid, m1_rready = 0;
    logic        s_arvalid, s_arready = 0, s_rvalid = 0, s_rready;
    int          errors = 0, checks = 0;

    localparam logic [31:0] A_LO = 32'h0200_BFF8, A_HI = 32'h0200_BFFC;

    clint_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .FIRST_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outs"}, {m0_arready, m0_rvalid, m0_rresp, m1_arready, m1_rvalid, m1_rresp,
                             s_arvalid, s_rready}, 64'h0);
        chk({tag, " data"}, {m0_rdata, m1_rdata}, 64'h0);
        chk({tag, " s_araddr"}, s_araddr, 64'h0);
    endtask

    initial begin
        // Reset with a request pending: arready must still be 0
        m0_arvalid = 1;
        #3 chk_all_zero("reset");
        m0_arvalid = 0;
        #9 rst = 1;
        tick();

        // Single m0 read
        m0_araddr = A_LO; m0_arvalid = 1; m0_rready = 1;
        #1 chk("t1 m0_arready", m0_arready, 1);
        chk("t1 m1_arready", m1_arready, 0);
        chk("t1 s_arvalid idle", s_arvalid, 0);
        tick();
        m0_arvalid = 0; s_arready = 1;
        #1 chk("t1 s_ar", {s_arvalid, s_araddr}, {1'b1, A_LO});
        chk("t1 m0_arready addr", m0_arready, 0);
        tick();
        s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_1234; s_rresp = 2'b00;
        #1 chk("t1 m0_r", {m0_rvalid, m0_rdata, m0_rresp}, {1'b1, 32'h1234, 2'b00});
        chk("t1 s_rready", s_rready, 1);
        chk("t1 m1_r", {m1_rvalid, m1_rdata, m1_rresp}, 0);
        tick();
        s_rvalid = 0;
        #1 chk("t1 done", {m0_rvalid, s_rready}, 0);

        // Reset pulse: the following contention must go to FIRST_PRIO, not round-robin
        #2 rst = 0;
        #2 rst = 1;
        tick();

        // Simultaneous requests
        m0_araddr = A_LO; m1_araddr = A_HI; m0_arvalid = 1; m1_arvalid = 1; m1_rready = 1;
        #1 chk("t2 arready pair", {m0_arready, m1_arready}, 2'b10);
        tick();
        m0_arvalid = 0; s_arready = 1;
        #1 chk("t2 s_araddr m0", s_araddr, A_LO);
        chk("t2 m1 locked addr", m1_arready, 0);
        tick();
        s_arready = 0; s_rvalid = 1; s_rdata = 32'h1111_0000;
        #1 chk("t2 m0 rdata", {m0_rvalid, m0_rdata}, {1'b1, 32'h1111_0000});
        chk("t2 m1 locked data", {m1_arready, m1_rvalid}, 0);
        tick();
        s_rvalid = 0;
        #1 chk("t2 m1_arready idle", m1_arready, 1);
        tick();
        m1_arvalid = 0; s_arready = 1;
        #1 chk("t2 s_araddr m1", s_araddr, A_HI);
        tick();
        s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_0002;
        #1 chk("t2 m1 rdata", {m1_rvalid, m1_rdata, m0_rvalid}, {1'b1, 32'h2, 1'b0});
        tick();
        s_rvalid = 0;

        // Continuous contention: strict alternation starting at m0 (last grant was m1)
        m0_arvalid = 1; m1_arvalid = 1;
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("t3 grant %0d", i), {m0_arready, m1_arready}, (i % 2) ? 2'b01 : 2'b10);
            tick();
            s_arready = 1;
            #1 chk($sformatf("t3 addr %0d", i), s_araddr, (i % 2) ? A_HI : A_LO);
            tick();
            s_arready = 0; s_rvalid = 1; s_rdata = ((i % 2) ? A_HI : A_LO) ^ 32'hA5A5_0000;
            #1 if (i % 2) chk($sformatf("t3 m1 data %0d", i), {m1_rvalid, m1_rdata}, {1'b1, A_HI ^ 32'hA5A5_0000});
            else chk($sformatf("t3 m0 data %0d", i), {m0_rvalid, m0_rdata}, {1'b1, A_LO ^ 32'hA5A5_0000});
            tick();
            s_rvalid = 0;
        end
        m0_arvalid = 0; m1_arvalid = 0;

        // m1 changes araddr after acceptance; latched address must be used
        m1_araddr = A_LO; m1_arvalid = 1;
        #1 chk("t5 m1_arready", m1_arready, 1);
        tick();
        m1_araddr = A_HI; m1_arvalid = 0;
        #1 chk("t5 s_araddr hold", s_araddr, A_LO);
        tick();
        s_arready = 1;
        #1 chk("t5 s_araddr accept", {s_arvalid, s_araddr}, {1'b1, A_LO});
        tick();
        s_arready = 0; s_rvalid = 1; s_rdata = 32'h55;
        #1 chk("t5 m1_rvalid", m1_rvalid, 1);
        tick();
        s_rvalid = 0;

        // Slave and master back-pressure on an m0 read
        m0_araddr = 32'h0200_4000; m0_arvalid = 1; m0_rready = 0;
        #1 chk("t4 m0_arready", m0_arready, 1);
        tick();
        m0_arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("t4 ar stall %0d", i), {s_arvalid, s_araddr}, {1'b1, 32'h0200_4000});
            tick();
        end
        s_arready = 1;
        #1 chk("t4 ar hs", s_arvalid, 1);
        tick();
        s_arready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("t4 r stall %0d", i), {m0_rvalid, s_arvalid}, 0);
            tick();
        end
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1 chk($sformatf("t4 bp %0d", i), {m0_rvalid, m0_rdata, m0_rresp, s_rready},
                   {1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0});
            tick();
        end
        m0_rready = 1;
        #1 chk("t4 s_rready", s_rready, 1);
        tick();
        s_rvalid = 0; s_rresp = 0;
        #1 chk("t4 single hs", {m0_rvalid, s_arvalid, s_rready}, 0);

        // Asynchronous reset while m1 owns DATA
        m1_araddr = A_HI; m1_arvalid = 1;
        #1 chk("t6 m1_arready", m1_arready, 1);
        tick();
        m1_arvalid = 0; s_arready = 1;
        tick();
        s_arready = 0; s_rvalid = 1; s_rdata = 32'h77; m1_rready = 0;
        #1 chk("t6 m1_rvalid pre", m1_rvalid, 1);
        m0_arvalid = 1; m1_arvalid = 1; m0_araddr = A_LO;
        #1 rst = 0;
        #1 chk_all_zero("t6 async");
        #1 rst = 1; s_rvalid = 0;
        #1 chk("t6 first prio", {m0_arready, m1_arready}, 2'b10);
        m0_arvalid = 0; m1_arvalid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clint_rd_arbiter.md
Name: clint_rd_arbiter

Overview:
- Two-master, one-slave arbiter for the AXI4-Lite read channels (AR/R) of the CLINT mtime timer.
- Master 0 is the IFU-side read port; master 1 is the LSU-side read port. Both share the single read-only CLINT slave.
- Exactly one read transaction is outstanding at a time. The grant is round-robin and is held from address acceptance until the R handshake completes.
- Sits between the core's memory-request crossbar and the CLINT slave.

Parameters:
- ADDR_W, 32, address width of all araddr ports.
- DATA_W, 32, data width of all rdata ports.
- FIRST_PRIO, 0, master that wins the first contended arbitration after reset (0 or 1).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- m0_araddr  input  ADDR_W  master 0 read address
- m0_arvalid  input  1  master 0 address valid
- m0_arready  output  1  master 0 address accepted
- m0_rdata  output  DATA_W  master 0 read data
- m0_rresp  output  2  master 0 response
- m0_rvalid  output  1  master 0 data valid
- m0_rready  input  1  master 0 data ready
- m1_*  same six signals and meanings as m0_*, for master 1
- s_araddr  output  ADDR_W  slave address
- s_arvalid  output  1  slave address valid
- s_arready  input  1  slave address ready
- s_rdata  input  DATA_W  slave data
- s_rresp  input  2  slave response
- s_rvalid  input  1  slave data valid
- s_rready  output  1  slave data ready

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; addr_q=0; owner=0.
  - last_grant = 1-FIRST_PRIO.
  - All outputs are 0: arready, rvalid, rdata, rresp on both masters, plus s_arvalid, s_araddr, s_rready.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Winner selection: if exactly one m*_arvalid is high, that master wins. If both are high, the winner is the master that is not last_grant.
  - The winner's m*_arready=1 combinationally in this cycle; the loser's arready=0. No arvalid means no arready.
  - On the clock edge where winner arvalid&&arready: addr_q<=winner araddr; owner<=winner; state->ADDR.
- ADDR:
  - s_arvalid=1, s_araddr=addr_q. Both m*_arready=0.
  - On s_arready=1: state->DATA.
  - Minimum latency: 1 cycle in ADDR.
- DATA:
  - s_rready = owner's m_rready.
  - Owner's rvalid/rdata/rresp are combinational from s_rvalid/s_rdata/s_rresp.
  - Non-owner: rvalid=0, rdata=0, rresp=0.
  - On s_rvalid&&owner rready: last_grant<=owner; state->IDLE.
- Outputs outside DATA: m*_rvalid=0, s_rready=0. s_arvalid=0 outside ADDR.
- Best-case round trip is 3 cycles: IDLE accept, ADDR, then DATA with the slave responding in the same cycle. The next request can be accepted in the cycle after R completes.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1…; neither master waits more than one transaction.
- Ownership lock: a request arriving from the non-owner during ADDR/DATA is held (arready=0) until IDLE. The master must keep arvalid and araddr stable, per AXI.
- Master address changes after acceptance have no effect; the latched addr_q is used.
- rresp is passed through unmodified. No error generation.
- Reset mid-transaction: immediate return to IDLE with the transaction dropped. The CLINT shares this reset, so no orphan response exists.
- Back-pressure: owner rready=0 holds DATA indefinitely, and s_rready stays 0.

Test Plan:
- Single m0 read of araddr=0x0200BFF8, slave returns 0x0000_1234/OKAY -> m0_arready=1 in the request cycle; s_arvalid=1 with s_araddr=0x0200BFF8 next cycle; m0_rvalid=1 with rdata=0x1234, rresp=0; m1 outputs stay 0.
- Simultaneous m0 (0x...BFF8) and m1 (0x...BFFC) requests after reset, FIRST_PRIO=0 -> m0 served first. m1's arready asserts only in the IDLE cycle after m0's R handshake, and m1 receives the high-word data.
- Both masters requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1; per-master rdata matches the address it issued.
- Slave holds s_arready=0 for 4 cycles and s_rvalid=0 for 3 cycles; owner holds rready=0 for 2 cycles after rvalid -> s_arvalid and rvalid stay high and stable; exactly one handshake each.
- m1 changes araddr from 0x...BFF8 to 0x...BFFC the cycle after acceptance -> s_araddr stays 0x...BFF8.
- Assert rst=0 asynchronously (mid-clock) while in DATA -> all outputs go to 0 without waiting for a clock edge. After release, the first contended grant goes to FIRST_PRIO.
